// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx_pkg                                                            |
// | Shared constants, state encoding and parity helper for the PS/2 host TX.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ps2_host_tx_pkg;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx_if                                                             |
// | Command handshake and status bundle between a requester and ps2_host_tx.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_line_sync                                                              |
// | Two-flop synchronizer for PS/2 clock and data with clock falling-edge out. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_line_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic ps2_clk_in,
    input  wire logic ps2_data_in,
    output logic      clk_sync,
    output logic      data_sync,
    output logic      clk_fall
);

    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_data_meta, r_data_sync;

    // Lines idle high, so reset to 1 to avoid a phantom edge on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    assign clk_sync  = r_clk_sync;
    assign data_sync = r_data_sync;
    assign clk_fall  = r_clk_prev & ~r_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx                                                                |
// | PS/2 host-to-device command transmitter (request-to-send, open-drain oe). |
// | Optional transfer watchdog: define PS2_TX_TIMEOUT_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = CLK_HZ / 10_000,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 50
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ps2_host_tx_if.slave  tx,
    input  wire logic     ps2_clk_in,
    input  wire logic     ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    // One counter serves both the inhibit interval and the watchdog: both run from accept
    localparam int c_cnt_max = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
`endif

    state_t               r_state, nxt_state;
    logic [c_cnt_w-1:0]   r_cnt, nxt_cnt;
    logic [3:0]           r_bitcnt, nxt_bitcnt;
    logic [8:0]           r_shift, nxt_shift;
    logic                 r_data_oe, nxt_data_oe;
    logic                 r_done, nxt_done;
    logic                 r_error, nxt_error;
    logic                 w_clk_sync, w_data_sync, w_clk_fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (w_clk_sync),
        .data_sync   (w_data_sync),
        .clk_fall    (w_clk_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= nxt_state;
            r_cnt     <= nxt_cnt;
            r_bitcnt  <= nxt_bitcnt;
            r_shift   <= nxt_shift;
            r_data_oe <= nxt_data_oe;
            r_done    <= nxt_done;
            r_error   <= nxt_error;
        end
    end

    always_comb begin
        nxt_state   = r_state;
        nxt_cnt     = r_cnt;
        nxt_bitcnt  = r_bitcnt;
        nxt_shift   = r_shift;
        nxt_data_oe = r_data_oe;
        nxt_done    = 1'b0;
        nxt_error   = 1'b0;
        if (r_state != IDLE) begin
            nxt_cnt = r_cnt + 1'b1;
        end
        case (r_state)
            IDLE: begin
                if (tx.tx_valid) begin
                    nxt_state   = INHIBIT;
                    nxt_cnt     = '0;
                    nxt_bitcnt  = '0;
                    nxt_shift   = {odd_parity(tx.tx_data), tx.tx_data};
                    nxt_data_oe = 1'b0;
                end
            end
            INHIBIT: begin
                if (r_cnt == c_inh_last) begin
                    nxt_state   = REQ;
                    nxt_data_oe = 1'b1;
                end
            end
            // An edge landing on the REQ->SEND step is the first SEND edge
            REQ, SEND: begin
                nxt_state = SEND;
                if (w_clk_fall) begin
                    nxt_bitcnt = r_bitcnt + 4'd1;
                    if (r_bitcnt < 4'd9) begin
                        nxt_data_oe = ~r_shift[0];
                        nxt_shift   = {1'b1, r_shift[8:1]};
                    end else if (r_bitcnt == 4'd9) begin
                        nxt_data_oe = 1'b0;
                    end else begin
                        nxt_bitcnt = '0;
                        if (!w_data_sync) begin
                            nxt_state = WAIT_IDLE;
                        end else begin
                            nxt_state = IDLE;
                            nxt_error = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) begin
                    nxt_state = IDLE;
                    nxt_done  = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog overrides whatever the same-cycle edge decided
        if (((r_state == SEND) || (r_state == WAIT_IDLE)) && (r_cnt == c_to_last)) begin
            nxt_state   = IDLE;
            nxt_data_oe = 1'b0;
            nxt_bitcnt  = '0;
            nxt_done    = 1'b0;
            nxt_error   = 1'b1;
        end
`endif
    end

    assign tx.tx_ready = (r_state == IDLE);
    assign tx.busy     = (r_state != IDLE);
    assign tx.done     = r_done;
    assign tx.error    = r_error;
    assign ps2_clk_oe  = (r_state == INHIBIT) || (r_state == REQ);
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire
